segmented_subtractor: RTL and testbench



---
 rtl/segmented_subtractor.sv | 152 +++++++++++++++
 tb/tb_segmented_subtractor.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/segmented_subtractor.sv
// Multi-cycle wide subtractor: result = in_a - in_b mod 2^WIDTH, processed one
// SEG_WIDTH segment per clock, least-significant segment first, through a
// registered borrow chain. borrow_out flags in_a < in_b (unsigned).
//
// Optional build macro: SEGSUB_COND_SUB_EN
//   Defined   - conditional subtraction: when the final borrow is set, result
//               returns the original in_a instead of the wrapped difference.
//   Undefined - result is always the wrapped difference.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   operation request, accepted only when not busy
//   in_a       in   minuend, captured on the accepting edge
//   in_b       in   subtrahend, captured on the accepting edge
//   result     out  difference, valid from done until the next DONE edge
//   borrow_out out  1 when in_a < in_b, valid with result
//   busy       out  high while segments are being processed
//   done       out  single-cycle pulse when result/borrow_out are updated
module segmented_subtractor #(
    parameter int unsigned WIDTH     = 1024,
    parameter int unsigned SEG_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] result,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned NSEG = WIDTH / SEG_WIDTH;
    localparam int unsigned CntW = (NSEG > 1) ? $clog2(NSEG) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic              borrow_q, borrow_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              borrow_out_q, borrow_out_d;

    logic [SEG_WIDTH:0]   sum;
    logic [SEG_WIDTH-1:0] seg;
    logic                 seg_borrow;
    logic                 last_seg;
    logic [WIDTH-1:0]     full_diff;

`ifdef SEGSUB_COND_SUB_EN
    logic [WIDTH-1:0] orig_a_q, orig_a_d;
`endif

    // a - b - borrow as a + ~b + ~borrow; carry out of the widened sum is the
    // inverted borrow.
    always_comb begin
        sum = {1'b0, a_q[SEG_WIDTH-1:0]} + {1'b0, ~b_q[SEG_WIDTH-1:0]}
            + {{SEG_WIDTH{1'b0}}, ~borrow_q};
        seg        = sum[SEG_WIDTH-1:0];
        seg_borrow = ~sum[SEG_WIDTH];
        last_seg   = (cnt_q == CntW'(NSEG - 1));
        // New segment enters at the MSB end; after NSEG shifts the LSB
        // segment has reached the bottom.
        full_diff  = {seg, acc_q[WIDTH-1:SEG_WIDTH]};
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        acc_d        = acc_q;
        borrow_d     = borrow_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        borrow_out_d = borrow_out_q;
`ifdef SEGSUB_COND_SUB_EN
        orig_a_d     = orig_a_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_d      = in_a;
                    b_d      = in_b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
`ifdef SEGSUB_COND_SUB_EN
                    orig_a_d = in_a;
`endif
                    state_d  = StCalc;
                end else begin
                    state_d  = StIdle;
                end
            end
            StCalc: begin
                a_d      = a_q >> SEG_WIDTH;
                b_d      = b_q >> SEG_WIDTH;
                acc_d    = full_diff;
                borrow_d = seg_borrow;
                cnt_d    = cnt_q + CntW'(1);
                if (last_seg) begin
`ifdef SEGSUB_COND_SUB_EN
                    result_d = seg_borrow ? orig_a_q : full_diff;
`else
                    result_d = full_diff;
`endif
                    borrow_out_d = seg_borrow;
                    state_d      = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            borrow_q     <= 1'b0;
            cnt_q        <= '0;
            result_q     <= '0;
            borrow_out_q <= 1'b0;
`ifdef SEGSUB_COND_SUB_EN
            orig_a_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            acc_q        <= acc_d;
            borrow_q     <= borrow_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            borrow_out_q <= borrow_out_d;
`ifdef SEGSUB_COND_SUB_EN
            orig_a_q     <= orig_a_d;
`endif
        end
    end

    assign result     = result_q;
    assign borrow_out = borrow_out_q;
    assign busy       = (state_q == StCalc);
    assign done       = (state_q == StDone);

endmodule

// File: tb/tb_segmented_subtractor.sv
// Directed bench for segmented_subtractor (WIDTH=1024, SEG_WIDTH=32).
module tb_segmented_subtractor;

    localparam int unsigned W    = 1024;
    localparam int unsigned LAT  = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] result;
    logic         borrow_out;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    segmented_subtractor #(
        .WIDTH     (W),
        .SEG_WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_a       (in_a),
        .in_b       (in_b),
        .result     (result),
        .borrow_out (borrow_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_wide(input string tag, input logic [W-1:0] obs,
                              input logic [W-1:0] exp);
        int idx;
        idx = -1;
        for (int i = W - 1; i >= 0; i--) if (obs[i] !== exp[i]) idx = i;
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed low128=%h expected low128=%h first diff bit %0d",
                   tag, obs[127:0], exp[127:0], idx);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue start for one edge (the accepting edge), then scramble the inputs.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        in_a  = a;
        in_b  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        in_a  = rand_wide();
        in_b  = rand_wide();
    endtask

    // Counts edges until done; optionally pulses a rogue start mid-operation.
    task automatic wait_done(input string tag, input bit inject);
        int n;
        bit seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < LAT + 8) begin
            @(posedge clk);
            #1;
            n++;
            if (inject && n == 5) begin
                start = 1'b1;
                in_a  = 1024'd7;
                in_b  = 1024'd9;
            end else if (inject && n == 6) begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                check_bit({tag, "_busy_at_done"}, busy, 1'b0);
            end else if (n < LAT) begin
                check_bit({tag, "_busy_during"}, busy, 1'b1);
            end
        end
        check_bit({tag, "_done_seen"}, seen, 1'b1);
        check_int({tag, "_latency"}, n, LAT);
    endtask

    task automatic check_res(input string tag, input logic [W-1:0] a,
                             input logic [W-1:0] b);
        logic [W-1:0] exp_r;
        logic         exp_b;
        exp_r = a - b;
        exp_b = (a < b);
`ifdef SEGSUB_COND_SUB_EN
        if (exp_b) exp_r = a;
`endif
        check_wide({tag, "_result"}, result, exp_r);
        check_bit({tag, "_borrow"}, borrow_out, exp_b);
    endtask

    // No done and no busy for a stretch of idle cycles.
    task automatic check_quiet(input string tag, input int cycles);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) bad = 1'b1;
        end
        check_bit({tag, "_quiet"}, bad, 1'b0);
    endtask

    initial begin
        logic [W-1:0] exp_w;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst   = 1'b1;
        start = 1'b0;
        in_a  = '0;
        in_b  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_wide("reset", result, '0);
        check_bit("reset_borrow", borrow_out, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_done", done, 1'b0);
        check_quiet("post_reset", 5);

        // 5 - 3
        start_op(1024'd5, 1024'd3);
        wait_done("sub_5_3", 1'b0);
        check_wide("sub_5_3_result", result, 1024'd2);
        check_bit("sub_5_3_borrow", borrow_out, 1'b0);

        // 3 - 5 wraps to all ones except bit 0
        start_op(1024'd3, 1024'd5);
        wait_done("sub_3_5", 1'b0);
        exp_w    = '1;
        exp_w[0] = 1'b0;
`ifdef SEGSUB_COND_SUB_EN
        exp_w    = 1024'd3;
`endif
        check_wide("sub_3_5_result", result, exp_w);
        check_bit("sub_3_5_borrow", borrow_out, 1'b1);

        // Borrow across the first segment boundary
        exp_w     = '0;
        exp_w[32] = 1'b1;
        start_op(exp_w, 1024'd1);
        wait_done("seg_borrow", 1'b0);
        check_wide("seg_borrow_result", result, 1024'h0000_0000_FFFF_FFFF);
        check_bit("seg_borrow_borrow", borrow_out, 1'b0);

        // Borrow through every segment
        start_op(1024'd0, 1024'd1);
        wait_done("zero_minus_one", 1'b0);
        exp_w = '1;
`ifdef SEGSUB_COND_SUB_EN
        exp_w = '0;
`endif
        check_wide("zero_minus_one_result", result, exp_w);
        check_bit("zero_minus_one_borrow", borrow_out, 1'b1);

        // A == B
        ra = rand_wide();
        start_op(ra, ra);
        wait_done("equal", 1'b0);
        check_wide("equal_result", result, '0);
        check_bit("equal_borrow", borrow_out, 1'b0);

        // Random sweep
        for (int v = 0; v < 200; v++) begin
            ra = rand_wide();
            rb = rand_wide();
            if (v % 4 == 1) rb[W-1 -: 64] = ra[W-1 -: 64];
            start_op(ra, rb);
            wait_done("rand", 1'b0);
            check_res("rand", ra, rb);
        end

        // Start mid-CALC is ignored
        start_op(1024'd100, 1024'd1);
        wait_done("ignore", 1'b1);
        check_wide("ignore_result", result, 1024'd99);
        check_bit("ignore_borrow", borrow_out, 1'b0);
        check_quiet("ignore_no_second", 40);
        check_wide("ignore_hold", result, 1024'd99);

        // Back-to-back start in the DONE cycle
        start_op(1024'd10, 1024'd4);
        wait_done("b2b_first", 1'b0);
        check_wide("b2b_first_result", result, 1024'd6);
        start_op(1024'd4, 1024'd10);
        check_bit("b2b_accept_busy", busy, 1'b1);
        check_wide("b2b_hold", result, 1024'd6);
        wait_done("b2b_second", 1'b0);
        check_res("b2b_second", 1024'd4, 1024'd10);

        // Reset at the 10th CALC edge
        start_op(rand_wide(), rand_wide());
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_done", done, 1'b0);
        check_wide("abort_result", result, '0);
        check_bit("abort_borrow", borrow_out, 1'b0);
        check_quiet("abort_no_done", 40);
        start_op(1024'd5, 1024'd3);
        wait_done("after_abort", 1'b0);
        check_wide("after_abort_result", result, 1024'd2);
        check_bit("after_abort_borrow", borrow_out, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
